camera_button_pulser: RTL and testbench

Conditions the four raw pushbutton inputs that steer the virtual camera: synchronizes and debounces each button and emits clean single-cycle move pulses, with optional auto-repeat while a button is held. Sits between the board buttons and the virtual camera's left/right/up/down inputs, which act on 0→1 transitions. Each output pulse therefore produces exactly one one-step offset change downstream.

---
 rtl/camera_button_pulser.sv | 212 +++++++++++++++++++++
 tb/tb_camera_button_pulser.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_button_pulser.sv
// camera_button_pulser
// Turns the four raw, bouncing camera pushbuttons into clean single-cycle
// move pulses. Each channel runs a 2-flop synchronizer, then a debouncer,
// then a pulse FSM. Left/right and up/down are locked out against each other.
// Build option: define CAM_BTN_REPEAT_EN to auto-repeat while a button is
// held. Without it, each debounced press yields exactly one pulse.

module camera_button_pulser #(
    parameter int unsigned DEBOUNCE_CYCLES = 650000,
    parameter int unsigned HOLD_CYCLES     = 32500000,
    parameter int unsigned REPEAT_CYCLES   = 6500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       left,
    output logic       right,
    output logic       up,
    output logic       down,
    output logic [3:0] held
);

    // Channel order matches held: [3]=up, [2]=down, [1]=left, [0]=right.
    logic [3:0] btn_raw;
    assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

    // Reject parameter values that the 26-bit timers or the pulse spacing
    // cannot honour.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES >= 2**26 ||
        HOLD_CYCLES < 2     || HOLD_CYCLES >= 2**26     ||
        REPEAT_CYCLES < 2   || REPEAT_CYCLES >= 2**26) begin : g_bad_params
        $error("camera_button_pulser: parameter out of range");
    end

    localparam logic [25:0] DB_LAST = 26'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic [3:0] sync1_q;
    logic [3:0] sync_q;

    // Two-flop synchronizer: raw button levels are asynchronous to clk.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments, so each flop samples the value it had before the edge.
        if (reset) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync_q  <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer
    // ------------------------------------------------------------------
    logic [3:0]  db_q;
    logic [3:0]  db_d;
    logic [25:0] db_cnt_q [4];
    logic [25:0] db_cnt_d [4];

    // Count the cycles in which the synchronized level disagrees with db.
    // Adopt the new level once it has disagreed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        db_d = db_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i] = sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 26'd1;
                end
            end
        end
    end

    // Debounced levels and their stability counters.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the counter array is ordinary flops, so it is cleared by reset like any scalar.
        if (reset) begin
            db_q <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pair lockout
    // ------------------------------------------------------------------
    // Opposing buttons held together cancel each other. A masked channel
    // behaves as if released.
    logic [3:0] lock;
    logic [3:0] elig;
    assign lock = {{2{db_q[3] & db_q[2]}}, {2{db_q[1] & db_q[0]}}};
    assign elig = db_q & ~lock;

    // ------------------------------------------------------------------
    // Pulse FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
`ifdef CAM_BTN_REPEAT_EN
        ST_HOLD_WAIT,
        ST_REPEAT_WAIT
`else
        ST_HELD
`endif
    } state_e;

    state_e     state_q [4];
    state_e     state_d [4];
    logic [3:0] pulse;

`ifdef CAM_BTN_REPEAT_EN
    localparam logic [25:0] HOLD_LOAD   = 26'(HOLD_CYCLES);
    localparam logic [25:0] REPEAT_LOAD = 26'(REPEAT_CYCLES);

    logic [25:0] timer_q [4];
    logic [25:0] timer_d [4];
`endif

    // Next state and pulse for each channel. Losing eligibility (release
    // or lockout) always returns the channel to IDLE and drops any pulse.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            pulse[i]   = 1'b0;
`ifdef CAM_BTN_REPEAT_EN
            timer_d[i] = timer_q[i];
`endif
            case (state_q[i])
                ST_IDLE: begin
                    if (elig[i]) begin
                        state_d[i] = ST_FIRST;
                    end
                end
                ST_FIRST: begin
                    if (!elig[i]) begin
                        state_d[i] = ST_IDLE;
                    end else begin
                        pulse[i] = 1'b1;
`ifdef CAM_BTN_REPEAT_EN
                        timer_d[i] = HOLD_LOAD;
                        state_d[i] = ST_HOLD_WAIT;
`else
                        state_d[i] = ST_HELD;
`endif
                    end
                end
`ifdef CAM_BTN_REPEAT_EN
                ST_HOLD_WAIT, ST_REPEAT_WAIT: begin
                    if (!elig[i]) begin
                        state_d[i] = ST_IDLE;
                    end else if (timer_q[i] == 26'd1) begin
                        pulse[i]   = 1'b1;
                        timer_d[i] = REPEAT_LOAD;
                        state_d[i] = ST_REPEAT_WAIT;
                    end else begin
                        timer_d[i] = timer_q[i] - 26'd1;
                    end
                end
`else
                ST_HELD: begin
                    if (!elig[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end
`endif
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    // FSM state (and repeat timer) registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_IDLE;
`ifdef CAM_BTN_REPEAT_EN
                timer_q[i] <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
`ifdef CAM_BTN_REPEAT_EN
                timer_q[i] <= timer_d[i];
`endif
            end
        end
    end

    assign right = pulse[0];
    assign left  = pulse[1];
    assign down  = pulse[2];
    assign up    = pulse[3];
    assign held  = db_q;

endmodule

// File: tb/tb_camera_button_pulser.sv
// Self-checking bench for camera_button_pulser.
// It runs the directed scenarios with small timing parameters, followed by a
// randomized phase. Every cycle is compared against a behavioural model that
// works from input history and run lengths. Honours CAM_BTN_REPEAT_EN.

module tb_camera_button_pulser;

    localparam int unsigned D = 4;
    localparam int unsigned H = 10;
    localparam int unsigned R = 3;
`ifdef CAM_BTN_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_left, btn_right, btn_up, btn_down;
    logic       left, right, up, down;
    logic [3:0] held;

    always #5 clk = ~clk;

    camera_button_pulser #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .left     (left),
        .right    (right),
        .up       (up),
        .down     (down),
        .held     (held)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- reference model ----------------
    // raw_hist holds raw samples for the last D+2 edges (oldest first).
    // The synchronized level after edge n is the raw sample from edge n-1.
    logic [3:0]   raw_hist [$];
    logic [3:0]   m_db;
    logic [3:0]   m_pulse;
    int           run_len [4];
    int           edge_n;
    logic [127:0] obs_vec [4];

    // Is a pulse due k cycles after the first pulse of an uninterrupted run?
    function automatic bit due(input int k);
        if (k == 0) return 1'b1;
        if (!REP) return 1'b0;
        if (k == H) return 1'b1;
        if (k > H && ((k - H) % R) == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        raw_hist.delete();
        for (int k = 0; k < D + 2; k++) raw_hist.push_back(4'b0000);
        m_db    = 4'b0000;
        m_pulse = 4'b0000;
        for (int c = 0; c < 4; c++) run_len[c] = 0;
    endtask

    task automatic model_edge(input logic [3:0] raw);
        bit         flip;
        logic [3:0] lk;
        logic [3:0] el;
        raw_hist.push_back(raw);
        while (raw_hist.size() > D + 2) void'(raw_hist.pop_front());
        // db toggles when the synchronized level has differed from it for
        // each of the last D cycles (entries 0..D-1 of the history).
        for (int c = 0; c < 4; c++) begin
            flip = 1'b1;
            for (int k = 0; k < D; k++) begin
                if (raw_hist[k][c] == m_db[c]) flip = 1'b0;
            end
            if (flip) m_db[c] = ~m_db[c];
        end
        lk = {{2{m_db[3] & m_db[2]}}, {2{m_db[1] & m_db[0]}}};
        el = m_db & ~lk;
        for (int c = 0; c < 4; c++) begin
            run_len[c] = el[c] ? run_len[c] + 1 : 0;
            m_pulse[c] = el[c] && (run_len[c] >= 2) && due(run_len[c] - 2);
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check_outputs(input string tag);
        logic [3:0] p;
        p = {up, down, left, right};
        tests_run++;
        assert (held === m_db) else begin
            tests_failed++;
            $error("FAIL %s held @%0d: got %b expected %b", tag, edge_n, held, m_db);
        end
        tests_run++;
        assert (p === m_pulse) else begin
            tests_failed++;
            $error("FAIL %s pulses{u,d,l,r} @%0d: got %b expected %b", tag, edge_n, p, m_pulse);
        end
        if (edge_n >= 0 && edge_n < 128) begin
            for (int c = 0; c < 4; c++) begin
                if (p[c] === 1'b1) obs_vec[c][edge_n] = 1'b1;
            end
        end
    endtask

    task automatic step(input string tag);
        logic [3:0] raw;
        raw = {btn_up, btn_down, btn_left, btn_right};
        @(posedge clk);
        if (reset) model_clear();
        else model_edge(raw);
        edge_n++;
        #1;
        check_outputs(tag);
    endtask

    task automatic begin_scn();
        edge_n = -1;
        for (int c = 0; c < 4; c++) obs_vec[c] = '0;
    endtask

    task automatic check_vec(input string tag, input int ch, input logic [127:0] exp);
        tests_run++;
        assert (obs_vec[ch] === exp) else begin
            tests_failed++;
            $error("FAIL %s: pulse-cycle map got %h expected %h", tag, obs_vec[ch], exp);
        end
    endtask

    // First pulse at 'first', then repeats (if enabled) up to cycle 'last'.
    function automatic logic [127:0] pulse_train(input int first, input int last);
        logic [127:0] v;
        int t;
        v = '0;
        v[first] = 1'b1;
        if (REP) begin
            t = first + H;
            while (t <= last) begin
                v[t] = 1'b1;
                t += R;
            end
        end
        return v;
    endfunction

    task automatic do_reset();
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        reset     = 1'b1;
        model_clear();
        #1;
        check_outputs("reset");
        step("reset");
        step("reset");
        reset = 1'b0;
    endtask

    initial begin
        edge_n = -1;
        for (int c = 0; c < 4; c++) obs_vec[c] = '0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        reset     = 1'b1;
        model_clear();
        #1;
        check_outputs("power_on");
        step("power_on");
        step("power_on");
        reset = 1'b0;

        // Repeat: left held for edges 0..29.
        begin_scn();
        btn_left = 1'b1;
        repeat (30) step("repeat");
        btn_left = 1'b0;
        repeat (12) step("repeat");
        check_vec("repeat_left", 1, pulse_train(6, 34));
        check_vec("repeat_right_quiet", 0, '0);

        // Glitch: up high for 3 cycles only.
        do_reset();
        begin_scn();
        btn_up = 1'b1;
        repeat (3) step("glitch");
        btn_up = 1'b0;
        repeat (10) step("glitch");
        check_vec("glitch_up", 3, '0);
        tests_run++;
        assert (held === 4'b0000) else begin
            tests_failed++;
            $error("FAIL glitch_held: got %b expected 0000", held);
        end

        // Bounce: down toggles every 2 cycles, then steady from edge 20.
        do_reset();
        begin_scn();
        for (int i = 0; i < 20; i++) begin
            btn_down = ((i / 2) % 2) == 0;
            step("bounce");
        end
        btn_down = 1'b1;
        repeat (10) step("bounce");
        btn_down = 1'b0;
        repeat (12) step("bounce");
        check_vec("bounce_down", 2, pulse_train(26, 34));

        // Lockout: left+right together; right released at edge 40.
        do_reset();
        begin_scn();
        btn_left  = 1'b1;
        btn_right = 1'b1;
        repeat (40) step("lockout");
        btn_right = 1'b0;
        repeat (20) step("lockout");
        btn_left = 1'b0;
        repeat (12) step("lockout");
        check_vec("lockout_left", 1, pulse_train(46, 64));
        check_vec("lockout_right", 0, '0);

        // Long hold: right held 60 cycles.
        do_reset();
        begin_scn();
        btn_right = 1'b1;
        repeat (60) step("long_hold");
        btn_right = 1'b0;
        repeat (12) step("long_hold");
        check_vec("long_hold_right", 0, pulse_train(6, 64));

        // Reset mid-hold: up held, reset after edge 20, released before edge 22.
        do_reset();
        begin_scn();
        btn_up = 1'b1;
        repeat (21) step("midreset");
        reset = 1'b1;
        model_clear();
        #1;
        check_outputs("midreset_drop");
        step("midreset");
        @(negedge clk);
        reset = 1'b0;
        repeat (10) step("midreset");
        btn_up = 1'b0;
        repeat (12) step("midreset");
        check_vec("midreset_up", 3, pulse_train(6, 20) | pulse_train(28, 37));

        // Randomized phase with one asynchronous reset in the middle.
        do_reset();
        edge_n = 1000;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) btn_left  = ~btn_left;
            if ($urandom_range(0, 11) == 0) btn_right = ~btn_right;
            if ($urandom_range(0, 15) == 0) btn_up    = ~btn_up;
            if ($urandom_range(0, 15) == 0) btn_down  = ~btn_down;
            if (i == 777) begin
                reset = 1'b1;
                model_clear();
                #1;
                check_outputs("random_reset");
                step("random_reset");
                reset = 1'b0;
            end
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
